// File: rtl/uart_bus_bridge_if.sv
// Shared debug/CPU bus as seen by one initiator.
//   cyc      bus cycle active
//   we       1 = write, 0 = read (valid while cyc)
//   addr     word address (byte address [31:2])
//   sel      byte lanes
//   data_out write data from the initiator
//   data_in  read data from the responder, valid with ack
//   ack      responder done
// master: initiator side (the bridge); slave: responder side.
interface uart_bus_bridge_if;
  logic        cyc;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        ack;

  modport master (
    output cyc, we, addr, sel, data_out,
    input  data_in, ack
  );

  modport slave (
    input  cyc, we, addr, sel, data_out,
    output data_in, ack
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART-driven debug bus initiator. Decodes 'W'/'R' command frames from the
// UART rx FIFO, runs one single-word bus cycle per frame and returns a status
// byte (plus read data) to the UART tx FIFO.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_data/rx_valid  head of the UART rx FIFO
//   rx_pop            consume rx_data this cycle
//   tx_data/tx_valid  byte offered to the UART tx FIFO, held until tx_ready
//   tx_ready          tx FIFO accepts tx_data
//   bus               initiator side of the shared cyc/we/addr/sel/ack bus
//
// state  | meaning
// IDLE   | waiting for a command byte
// ADDR   | collecting A0..A3
// DATA   | collecting D0..D3 (writes only)
// BUS    | cyc asserted, waiting for ack or bus timeout
// RESP   | shifting status/read data out to the tx FIFO
module uart_bus_bridge #(
  parameter int BUS_TIMEOUT   = 256,
  parameter int FRAME_TIMEOUT = 4800000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  uart_bus_bridge_if.master bus
);

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LOAD = BT_W'(BUS_TIMEOUT - 1);
  localparam logic [FT_W-1:0] FT_LOAD = FT_W'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            is_write;
  logic [1:0]      byte_cnt;
  logic [29:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [39:0]     rsp_buf;
  logic [2:0]      rsp_left;
  logic [BT_W-1:0] bus_tmr;
  logic [FT_W-1:0] frame_tmr;
  logic            known_cmd;

  assign known_cmd = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_valid) state_nxt = known_cmd ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_nxt = is_write ? S_DATA : S_BUS;
        end else if (frame_tmr == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_nxt = S_BUS;
        end else if (frame_tmr == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_BUS: begin
        if (bus.ack || (bus_tmr == '0)) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (tx_ready && (rsp_left == 3'd0)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Everything is derived from the registered state so an async reset
  // drops cyc and tx_valid immediately.
  always_comb begin
    rx_pop       = rx_valid && ((state == S_IDLE) || (state == S_ADDR) || (state == S_DATA));
    tx_valid     = (state == S_RESP);
    tx_data      = rsp_buf[7:0];
    bus.cyc      = (state == S_BUS);
    bus.we       = (state == S_BUS) && is_write;
    bus.sel      = (state == S_BUS) ? 4'hF : 4'h0;
    bus.addr     = addr_q;
    bus.data_out = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write  <= 1'b0;
      byte_cnt  <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_buf   <= '0;
      rsp_left  <= 3'd0;
      bus_tmr   <= '0;
      frame_tmr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            is_write  <= (rx_data == CMD_WRITE);
            byte_cnt  <= 2'd0;
            frame_tmr <= FT_LOAD;
            if (!known_cmd) begin
              rsp_buf  <= {32'h0, RSP_UNKNOWN};
              rsp_left <= 3'd0;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            byte_cnt  <= byte_cnt + 2'd1;
            frame_tmr <= FT_LOAD;
            bus_tmr   <= BT_LOAD;
            // Shifting 8 bits into a 30-bit register drops A0[1:0] on the
            // final byte, leaving the word address directly.
            if (state == S_ADDR) addr_q  <= {rx_data, addr_q[29:8]};
            else                 wdata_q <= {rx_data, wdata_q[31:8]};
          end else if (frame_tmr != '0) begin
            frame_tmr <= frame_tmr - 1'b1;
          end
        end
        S_BUS: begin
          if (bus.ack) begin
            if (is_write) begin
              rsp_buf  <= {32'h0, RSP_OK};
              rsp_left <= 3'd0;
            end else begin
              rsp_buf  <= {bus.data_in, RSP_OK};
              rsp_left <= 3'd4;
            end
          end else if (bus_tmr == '0) begin
            rsp_buf  <= {32'h0, RSP_TIMEOUT};
            rsp_left <= 3'd0;
          end else begin
            bus_tmr <= bus_tmr - 1'b1;
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            rsp_buf <= {8'h00, rsp_buf[39:8]};
            if (rsp_left != 3'd0) rsp_left <= rsp_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: directed frames, randomized frames
// with random rx gaps / tx backpressure / ack latency, frame-timeout boundary,
// tx backpressure hold and mid-cycle reset.
module tb_uart_bus_bridge;
  localparam int BT = 8;
  localparam int FT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  uart_bus_bridge_if bus_if ();

  uart_bus_bridge #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_got[$];
  bit          rx_hold = 1'b0;
  bit          gap_en = 1'b0;
  int          tx_mode = 0;
  int          ack_dly = 0;
  logic [31:0] rdata = 32'h0;
  int          n_ops = 0;
  int          ops_base = 0;
  int          last_len = 0;
  int          cyc_cnt = 0;
  logic [29:0] rec_addr = '0;
  logic        rec_we = 1'b0;
  logic [31:0] rec_wdata = '0;
  logic [3:0]  rec_sel = '0;
  bit          pend = 1'b0;
  logic [7:0]  pend_data = 8'h00;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // rx FIFO model: present head byte, drop it when the DUT pops
  always begin
    @(negedge clk);
    if (rx_q.size() > 0 && !rx_hold && !(gap_en && $urandom_range(0, 3) == 0)) begin
      rx_valid = 1'b1;
      rx_data  = rx_q[0];
    end else begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom());
    end
    #1;
    chk("pop_without_valid", 64'(rx_pop & ~rx_valid), 64'(0));
    chk("pop_while_busy", 64'(rx_pop & (bus_if.cyc | tx_valid)), 64'(0));
    if (rx_valid && rx_pop) void'(rx_q.pop_front());
  end

  // tx FIFO model with selectable readiness and hold-stability check
  always begin
    @(negedge clk);
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 2) != 0);
      default: tx_ready = 1'b0;
    endcase
    #1;
    if (!rst_n) pend = 1'b0;
    if (pend) begin
      chk("tx_hold_valid", 64'(tx_valid), 64'(1));
      chk("tx_hold_data", 64'(tx_data), 64'(pend_data));
    end
    if (tx_valid && tx_ready) tx_got.push_back(tx_data);
    pend      = tx_valid && !tx_ready;
    pend_data = tx_data;
  end

  // bus responder: ack in cycle ack_dly of cyc (never if negative);
  // random ack while idle must be ignored
  always begin
    @(negedge clk);
    if (bus_if.cyc) begin
      if (cyc_cnt == 0) begin
        n_ops++;
        rec_addr  = bus_if.addr;
        rec_we    = bus_if.we;
        rec_wdata = bus_if.data_out;
        rec_sel   = bus_if.sel;
      end else begin
        chk("bus_stable_addr", 64'(bus_if.addr), 64'(rec_addr));
        chk("bus_stable_we", 64'(bus_if.we), 64'(rec_we));
        chk("bus_stable_wdata", 64'(bus_if.data_out), 64'(rec_wdata));
        chk("bus_stable_sel", 64'(bus_if.sel), 64'(rec_sel));
      end
      cyc_cnt++;
      if (ack_dly >= 0 && cyc_cnt == ack_dly + 1) begin
        bus_if.ack     = 1'b1;
        bus_if.data_in = rdata;
      end else begin
        bus_if.ack     = 1'b0;
        bus_if.data_in = $urandom();
      end
    end else begin
      if (cyc_cnt != 0) last_len = cyc_cnt;
      cyc_cnt        = 0;
      bus_if.ack     = 1'($urandom_range(0, 1));
      bus_if.data_in = $urandom();
    end
  end

  task automatic push_frame(input logic [7:0] cmd, input logic [31:0] baddr, input logic [31:0] wdata);
    rx_q.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int i = 0; i < 4; i++) rx_q.push_back(8'(baddr >> (8 * i)));
    if (cmd == 8'h57)
      for (int i = 0; i < 4; i++) rx_q.push_back(8'(wdata >> (8 * i)));
  endtask

  task automatic prep(input int dly, input logic [31:0] rd);
    ops_base = n_ops;
    tx_got.delete();
    ack_dly  = dly;
    rdata    = rd;
  endtask

  // reference model: expected bus op and response bytes from the frame
  task automatic check_result(input logic [7:0] cmd, input logic [31:0] baddr,
                              input logic [31:0] wdata, input int dly);
    logic [7:0] exp_tx[$];
    bit         has_bus;
    int         exp_len;
    int         w;
    has_bus = (cmd == 8'h57) || (cmd == 8'h52);
    if (!has_bus) exp_tx.push_back(8'h3F);
    else if (dly < 0) exp_tx.push_back(8'h54);
    else begin
      exp_tx.push_back(8'h4B);
      if (cmd == 8'h52)
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rdata >> (8 * i)));
    end
    exp_len = (dly < 0) ? BT : dly + 1;
    w = 0;
    while (tx_got.size() < exp_tx.size() && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("resp_wait", 64'(tx_got.size() >= exp_tx.size()), 64'(1));
    repeat (3) @(negedge clk);
    chk("resp_len", 64'(tx_got.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < tx_got.size()) chk("resp_byte", 64'(tx_got[i]), 64'(exp_tx[i]));
    chk("bus_ops", 64'(n_ops - ops_base), 64'(has_bus));
    if (has_bus) begin
      chk("bus_addr", 64'(rec_addr), 64'(baddr >> 2));
      chk("bus_we", 64'(rec_we), 64'(cmd == 8'h57));
      if (cmd == 8'h57) chk("bus_wdata", 64'(rec_wdata), 64'(wdata));
      chk("bus_sel", 64'(rec_sel), 64'(4'hF));
      chk("cyc_len", 64'(last_len), 64'(exp_len));
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] baddr,
                           input logic [31:0] wdata, input int dly, input logic [31:0] rd);
    prep(dly, rd);
    push_frame(cmd, baddr, wdata);
    check_result(cmd, baddr, wdata, dly);
  endtask

  task automatic wait_rx_empty();
    for (int w = 0; w < 300 && rx_q.size() != 0; w++) @(posedge clk);
    chk("rx_drain", 64'(rx_q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd;
    int         k;
    int         dly;
    int         w;

    rst_n = 1'b0;
    #12;
    chk("rst_rx_pop", 64'(rx_pop), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_cyc", 64'(bus_if.cyc), 64'(0));
    chk("rst_we", 64'(bus_if.we), 64'(0));
    chk("rst_addr", 64'(bus_if.addr), 64'(0));
    chk("rst_sel", 64'(bus_if.sel), 64'(0));
    chk("rst_data_out", 64'(bus_if.data_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(8'h57, 32'h0000_0800, 32'hDEAD_BEEF, 2, $urandom());
    run_frame(8'h52, 32'h0000_0800, 32'h0, 0, 32'h1234_5678);
    run_frame(8'h52, 32'h0000_1000, 32'h0, -1, 32'h0);
    run_frame(8'h41, 32'h0, 32'h0, 0, 32'h0);
    run_frame(8'h52, 32'h0000_0404, 32'h0, 1, $urandom());

    // silence of FT-1 cycles mid-frame must not abort
    prep(1, $urandom());
    rx_q.push_back(8'h52);
    rx_q.push_back(8'h00);
    wait_rx_empty();
    rx_hold = 1'b1;
    repeat (FT - 1) @(posedge clk);
    rx_hold = 1'b0;
    rx_q.push_back(8'h08);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h00);
    check_result(8'h52, 32'h0000_0800, 32'h0, 1);

    // full frame timeout: partial frame dropped silently
    prep(0, 32'h0);
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h08);
    wait_rx_empty();
    repeat (FT + 10) @(negedge clk);
    chk("ft_no_bus", 64'(n_ops - ops_base), 64'(0));
    chk("ft_no_tx", 64'(tx_got.size()), 64'(0));
    run_frame(8'h52, 32'h0000_2000, 32'h0, 0, $urandom());

    // randomized frames
    gap_en  = 1'b1;
    tx_mode = 1;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      if (k < 4) cmd = 8'h57;
      else if (k < 8) cmd = 8'h52;
      else begin
        cmd = 8'($urandom());
        if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
      end
      dly = $urandom_range(0, 5);
      if (dly == 5) dly = -1;
      run_frame(cmd, $urandom(), $urandom(), dly, $urandom());
    end
    gap_en  = 1'b0;
    tx_mode = 0;
    repeat (3) @(negedge clk);

    // tx backpressure during read response, rx must not be popped
    tx_mode = 2;
    prep(0, $urandom());
    push_frame(8'h52, 32'h0000_0C00, 32'h0);
    w = 0;
    while (!tx_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("bp_tx_seen", 64'(tx_valid), 64'(1));
    push_frame(8'h52, 32'h0000_0C04, 32'h0);
    repeat (10) begin
      @(negedge clk);
      #2;
      chk("bp_tx_data", 64'(tx_data), 64'(8'h4B));
      chk("bp_tx_valid", 64'(tx_valid), 64'(1));
      chk("bp_no_pop", 64'(rx_pop), 64'(0));
    end
    chk("bp_rx_pending", 64'(rx_q.size()), 64'(5));
    tx_mode = 0;
    check_result(8'h52, 32'h0000_0C00, 32'h0, 0);
    prep(0, rdata);
    check_result(8'h52, 32'h0000_0C04, 32'h0, 0);

    // async reset in the middle of a bus cycle
    prep(-1, 32'h0);
    push_frame(8'h52, 32'h0000_3000, 32'h0);
    w = 0;
    while (!bus_if.cyc && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_cyc_seen", 64'(bus_if.cyc), 64'(1));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_drop", 64'(bus_if.cyc), 64'(0));
    chk("rst_mid_tx_idle", 64'(tx_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BT + 10) @(negedge clk);
    chk("rst_mid_no_tx", 64'(tx_got.size()), 64'(0));
    chk("rst_mid_no_cyc", 64'(bus_if.cyc), 64'(0));
    run_frame(8'h57, 32'h0000_0044, 32'h0BAD_F00D, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
